// File: rtl/norm_factor_gen.sv
// norm_factor_gen
// Per-frame normalisation-factor generator. Tracks the maximum pixel value of
// each frame on the incoming stream and, at end of frame, computes
//   norm_factor = floor((2^FRAC_WIDTH - 1) / frame_max)
// with a sequential restoring divider (one quotient bit per cycle). The factor
// feeds a downstream integer-by-fraction multiplier so that pixel*norm_factor
// never exceeds the fractional full scale on the following frame.
// FRAC_WIDTH must be >= INT_WIDTH so the divisor fits in the remainder path.

module norm_factor_gen #(
  parameter int INT_WIDTH  = 8,
  parameter int FRAC_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_valid,
  input  logic [INT_WIDTH-1:0]  pix_data,
  input  logic                  pix_last,
  output logic [FRAC_WIDTH-1:0] norm_factor,
  output logic                  norm_valid,
  output logic [INT_WIDTH-1:0]  frame_max,
  output logic                  busy,
  output logic                  overrun
);

  // FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DIV  = 1'b1;

  // Iteration counter sized to hold 0..FRAC_WIDTH
  localparam int CNT_W = $clog2(FRAC_WIDTH + 1);
  localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]      LAST_STEP = CNT_W'(FRAC_WIDTH - 1);
  localparam logic [FRAC_WIDTH-1:0] ALL_ONES  = {FRAC_WIDTH{1'b1}};
  localparam logic [FRAC_WIDTH-1:0] FRAC_ZERO = {FRAC_WIDTH{1'b0}};
  localparam logic [INT_WIDTH-1:0]  INT_ZERO  = {INT_WIDTH{1'b0}};

  // Unsigned maximum of two pixel values
  function automatic logic [INT_WIDTH-1:0] umax(
    input logic [INT_WIDTH-1:0] a,
    input logic [INT_WIDTH-1:0] b
  );
    if (a >= b) begin
      umax = a;
    end else begin
      umax = b;
    end
  endfunction

  // Zero-extend a pixel-width value to the remainder-compare width
  function automatic logic [FRAC_WIDTH:0] zext_div(input logic [INT_WIDTH-1:0] v);
    zext_div = {{(FRAC_WIDTH + 1 - INT_WIDTH){1'b0}}, v};
  endfunction

  // State registers and next-state values
  logic [0:0]            state_q, state_d;
  logic                  first_q, first_d;
  logic [INT_WIDTH-1:0]  acc_q,   acc_d;
  logic [INT_WIDTH-1:0]  div_q,   div_d;
  logic [FRAC_WIDTH-1:0] rem_q,   rem_d;
  logic [FRAC_WIDTH-1:0] quo_q,   quo_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [FRAC_WIDTH-1:0] nf_q,    nf_d;
  logic                  nv_q,    nv_d;
  logic [INT_WIDTH-1:0]  fmax_q,  fmax_d;
  logic                  ovr_q,   ovr_d;

  // Combinational helpers
  logic [INT_WIDTH-1:0]  beat_max_s;
  logic                  frame_end_s;
  logic [FRAC_WIDTH:0]   rem_shift_s;
  logic [FRAC_WIDTH:0]   div_ext_s;
  logic                  step_ge_s;
  logic [FRAC_WIDTH-1:0] rem_step_s;
  logic [FRAC_WIDTH-1:0] quo_step_s;

  // Frame-max candidate for the current beat and one restoring-division step.
  // The dividend is all ones, so every step shifts a 1 into the remainder.
  // The remainder stays below the divisor, so it always fits FRAC_WIDTH bits.
  always_comb begin
    frame_end_s = pix_valid & pix_last;
    if (first_q) begin
      beat_max_s = pix_data;
    end else begin
      beat_max_s = umax(acc_q, pix_data);
    end
    rem_shift_s = {rem_q, 1'b1};
    div_ext_s   = zext_div(div_q);
    step_ge_s   = (rem_shift_s >= div_ext_s);
    if (step_ge_s) begin
      rem_step_s = FRAC_WIDTH'(rem_shift_s - div_ext_s);
    end else begin
      rem_step_s = FRAC_WIDTH'(rem_shift_s);
    end
    quo_step_s = FRAC_WIDTH'({quo_q, step_ge_s});
  end

  // Running max accumulator; restarts after every last beat, even a dropped one
  always_comb begin
    first_d = first_q;
    acc_d   = acc_q;
    if (pix_valid) begin
      acc_d = beat_max_s;
      if (pix_last) begin
        first_d = 1'b1;
      end else begin
        first_d = 1'b0;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Divider FSM: latch divisor on end of frame, iterate FRAC_WIDTH steps, publish
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    nf_d    = nf_q;
    fmax_d  = fmax_q;
    nv_d    = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_end_s) begin
          state_d = ST_DIV;
          div_d   = beat_max_s;
          rem_d   = FRAC_ZERO;
          quo_d   = FRAC_ZERO;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        rem_d = rem_step_s;
        quo_d = quo_step_s;
        cnt_d = cnt_q + CNT_ONE;
        // A frame ending mid-division is dropped and flagged
        if (frame_end_s) begin
          ovr_d = 1'b1;
        end else begin
          ovr_d = 1'b0;
        end
        if (cnt_q == LAST_STEP) begin
          state_d = ST_IDLE;
          nv_d    = 1'b1;
          fmax_d  = div_q;
          // All-black frame: saturate rather than rely on divide-by-zero bits
          if (div_q == INT_ZERO) begin
            nf_d = ALL_ONES;
          end else begin
            nf_d = quo_step_s;
          end
        end else begin
          state_d = ST_DIV;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State update with asynchronous reset to the all-ones factor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      first_q <= 1'b1;
      acc_q   <= INT_ZERO;
      div_q   <= INT_ZERO;
      rem_q   <= FRAC_ZERO;
      quo_q   <= FRAC_ZERO;
      cnt_q   <= CNT_ZERO;
      nf_q    <= ALL_ONES;
      nv_q    <= 1'b0;
      fmax_q  <= INT_ZERO;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      nf_q    <= nf_d;
      nv_q    <= nv_d;
      fmax_q  <= fmax_d;
      ovr_q   <= ovr_d;
    end
  end

  assign norm_factor = nf_q;
  assign norm_valid  = nv_q;
  assign frame_max   = fmax_q;
  assign busy        = (state_q == ST_DIV);
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_norm_factor_gen.sv
// Testbench for norm_factor_gen: directed test-plan steps plus random frames,
// checked cycle by cycle against an event-level reference model.

module tb_norm_factor_gen;

  localparam int F    = 8;
  localparam int FULL = 255;

  logic       clk;
  logic       rst_n;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_last;
  logic [7:0] norm_factor;
  logic       norm_valid;
  logic [7:0] frame_max;
  logic       busy;
  logic       overrun;

  norm_factor_gen #(.INT_WIDTH(8), .FRAC_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_last(pix_last), .norm_factor(norm_factor), .norm_valid(norm_valid),
    .frame_max(frame_max), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  // Reference model state: beats of the current frame, and at most one division
  int q[$];
  bit act;
  int c0, due, p_nf, p_max, m_nf, m_fmax, ovr_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    act = 1'b0;
    m_nf = FULL;
    m_fmax = 0;
    ovr_cyc = -1;
  endtask

  // Beat presented during cycle cyc
  task automatic model_beat(input logic v, input logic [7:0] d, input logic l);
    int mx;
    if (v) begin
      q.push_back(int'(d));
      if (l) begin
        mx = 0;
        foreach (q[i]) if (q[i] > mx) mx = q[i];
        q.delete();
        if (act && cyc >= c0 + 1 && cyc <= c0 + F) begin
          ovr_cyc = cyc + 1;
        end else begin
          act   = 1'b1;
          c0    = cyc;
          due   = cyc + F + 1;
          p_max = mx;
          p_nf  = (mx == 0) ? FULL : FULL / mx;
        end
      end
    end
  endtask

  // Compare all outputs for the cycle just entered
  task automatic model_check();
    logic exp_nv, exp_busy;
    exp_nv = act && (cyc == due);
    if (exp_nv) begin
      m_nf   = p_nf;
      m_fmax = p_max;
      act    = 1'b0;
    end
    exp_busy = act && (cyc >= c0 + 1) && (cyc <= c0 + F);
    chk("norm_valid",  norm_valid,  exp_nv);
    chk("busy",        busy,        exp_busy);
    chk("overrun",     overrun,     cyc == ovr_cyc);
    chk("norm_factor", norm_factor, m_nf);
    chk("frame_max",   frame_max,   m_fmax);
  endtask

  task automatic tick(input logic v, input logic [7:0] d, input logic l);
    pix_valid = v;
    pix_data  = d;
    pix_last  = l;
    if (rst_n) model_beat(v, d, l);
    @(posedge clk);
    #1;
    cyc++;
    model_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    int n, gap, mxv;
    logic [7:0] v;
    rst_n = 1'b0;
    pix_valid = 1'b0;
    pix_data = 8'd0;
    pix_last = 1'b0;
    model_reset();

    // Reset state
    @(posedge clk); #1; cyc++;
    @(posedge clk); #1; cyc++;
    model_check();
    rst_n = 1'b1;

    // 1: ramp 0..15, max 15 -> 17
    for (int i = 0; i < 16; i++) tick(1'b1, 8'(i), i == 15);
    idle(F);
    chk("t1_nv_latency", norm_valid, 1'b1);
    idle(3);
    chk("t1_factor", norm_factor, 8'd17);
    chk("t1_max", frame_max, 8'd15);

    // 2: 255 only on last beat
    for (int i = 0; i < 7; i++) tick(1'b1, 8'd10, 1'b0);
    tick(1'b1, 8'd255, 1'b1);
    idle(12);
    chk("t2_factor", norm_factor, 8'd1);
    chk("t2_max", frame_max, 8'd255);

    // 3: all-zero frame, then single-beat frame of 3
    for (int i = 0; i < 5; i++) tick(1'b1, 8'd0, i == 4);
    idle(12);
    chk("t3_zero_factor", norm_factor, 8'd255);
    chk("t3_zero_max", frame_max, 8'd0);
    tick(1'b1, 8'd3, 1'b1);
    idle(12);
    chk("t3_single_factor", norm_factor, 8'd85);
    chk("t3_single_max", frame_max, 8'd3);

    // 4: overrun on a frame ending mid-division
    tick(1'b1, 8'd7, 1'b0);
    tick(1'b1, 8'd100, 1'b0);
    tick(1'b1, 8'd3, 1'b1);
    tick(1'b1, 8'd20, 1'b0);
    tick(1'b1, 8'd50, 1'b0);
    tick(1'b1, 8'd1, 1'b0);
    tick(1'b1, 8'd9, 1'b1);
    chk("t4_overrun", overrun, 1'b1);
    idle(12);
    chk("t4_factor", norm_factor, 8'd2);
    chk("t4_max", frame_max, 8'd100);
    for (int i = 0; i < 10; i++) tick(1'b1, (i == 6) ? 8'd200 : 8'($urandom_range(0, 200)), i == 9);
    idle(12);
    chk("t4_next_factor", norm_factor, 8'd1);
    chk("t4_next_max", frame_max, 8'd200);

    // 5: reset during cycle 4 of a division
    tick(1'b1, 8'd9, 1'b0);
    tick(1'b1, 8'd40, 1'b1);
    idle(3);
    chk("t5_busy_before_abort", busy, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("t5_rst_factor", norm_factor, 8'd255);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_max", frame_max, 8'd0);
    idle(2);
    rst_n = 1'b1;
    idle(F + 2);
    tick(1'b1, 8'd1, 1'b0);
    tick(1'b1, 8'd5, 1'b0);
    tick(1'b1, 8'd2, 1'b1);
    idle(F);
    chk("t5_nv_latency", norm_valid, 1'b1);
    chk("t5_factor", norm_factor, 8'd51);
    idle(3);

    // 6: gaps, then a last beat exactly when norm_valid pulses
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, (i == 4) ? 8'd60 : 8'($urandom_range(0, 59)), i == 11);
      if ($urandom_range(0, 1) == 1) tick(1'b0, 8'($urandom_range(0, 255)), 1'b1);
    end
    for (int i = 0; i < F; i++) begin
      tick(1'b1, (i == 2) ? 8'd17 : 8'($urandom_range(0, 16)), 1'b0);
    end
    chk("t6_nv", norm_valid, 1'b1);
    chk("t6_first_factor", norm_factor, 8'd4);
    tick(1'b1, 8'd4, 1'b1);
    idle(12);
    chk("t6_second_factor", norm_factor, 8'd15);
    chk("t6_second_max", frame_max, 8'd17);

    // Random frames with random gaps and inter-frame idle (some overruns)
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(1, 20);
      mxv = $urandom_range(0, 255);
      for (int i = 0; i < n; i++) begin
        v = 8'($urandom_range(0, mxv));
        tick(1'b1, v, i == n - 1);
        gap = $urandom_range(0, 3);
        if (gap == 0) tick(1'b0, 8'($urandom), 1'($urandom));
      end
      idle($urandom_range(0, 12));
    end
    idle(12);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
